// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Purpose:
//   Stall/flush controller for a 5-stage CPU. It takes requests from the
//   EXE-stage hazard/forwarding unit and drives the enables, flushes and
//   bubbles of the pipeline:
//     - a taken branch redirects the PC and flushes IF/ID and ID/EX
//     - a load-use hazard (wrn low) stalls the front end for one cycle
//     - a mul/div op freezes the pipeline for MD_CYCLES cycles
//   The controller owns the mul/div busy down-counter and the one-shot
//   load-use stall FSM (RUN / LU_STALL / MD_BUSY).
//
// Parameters:
//   MD_CYCLES  EXE occupancy of a mul/div op in cycles (2 .. 2**CNT_W)
//   CNT_W      width of the mul/div down-counter
//   PERF_W     width of each performance counter
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   wrn           in   load-use stall request, active-low
//   br_taken      in   EXE branch/jump resolved taken
//   md_start      in   mul/div instruction in EXE, first cycle
//   pc_en         out  PC register load enable
//   pc_sel        out  1 = PC loads branch target, 0 = PC+4
//   ifid_en       out  IF/ID register load enable
//   ifid_flush    out  IF/ID cleared to NOP on the next edge
//   idex_bubble   out  ID/EX loads NOP
//   idex_en       out  ID/EX register load enable
//   exmem_bubble  out  EX/MEM loads NOP
//   md_busy       out  mul/div occupying EXE
//   md_done       out  one-cycle pulse, mul/div result valid in EXE
//   stall_cycles  out  cycles with pc_en==0 outside reset
//   flush_count   out  number of branch flushes
//
// Configuration macro:
//   HAZ_PERF_EN   when defined, stall_cycles and flush_count are saturating
//                 counters; when undefined both ports are tied to zero and
//                 no counter flops exist.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrn,
    input  logic              br_taken,
    input  logic              md_start,
    output logic              pc_en,
    output logic              pc_sel,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              idex_en,
    output logic              exmem_bubble,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    // The md_start cycle is the first of MD_CYCLES and the counter==0 cycle
    // is the last, so the counter starts two below the occupancy.
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_nxt;

    // Outputs and next state are decoded from the current state and the
    // live requests. Reset overrides everything and presents a fully
    // bubbled, frozen pipeline. In RUN a taken branch wins over both the
    // mul/div start and the load-use request because those belong to
    // wrong-path instructions that are being flushed anyway.
    always_comb begin
        pc_en        = 1'b1;
        pc_sel       = 1'b0;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_en      = 1'b1;
        exmem_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = RUN;
            md_cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (br_taken) begin
                        pc_sel      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (md_start) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        md_busy      = 1'b1;
                        exmem_bubble = 1'b1;
                        md_cnt_nxt   = MD_LOAD;
                        state_nxt    = MD_BUSY;
                    end else if (!wrn) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        state_nxt   = LU_STALL;
                    end
                end

                // One cycle of free flow after a load-use stall; wrn is not
                // looked at here so a stuck request cannot deadlock the CPU.
                LU_STALL: begin
                    if (br_taken) begin
                        pc_sel      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                    state_nxt = RUN;
                end

                // Upstream is frozen, so every request input is ignored.
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (md_cnt == '0) begin
                        md_done   = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_bubble = 1'b1;
                        md_cnt_nxt   = md_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state_nxt  = RUN;
                    md_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

`ifdef HAZ_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (ifid_flush && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
